// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: hands out rename tags, collects CDB results, and retires
// the oldest ready entry onto the regfile write port. A mispredicted branch at retire triggers a rollback.
module rob_commit_unit #(
    parameter int ROB_BIT  = 4,
    parameter int ROB_SIZE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rob_st,
    input  logic               id_alloc_ena,
    input  logic [4:0]         id_alloc_rd,
    output logic               rob_full,
    output logic [ROB_BIT-1:0] id_rn_idx,
    input  logic [ROB_BIT-1:0] id_qry1_idx,
    input  logic [ROB_BIT-1:0] id_qry2_idx,
    output logic               id_qry1_rdy,
    output logic               id_qry2_rdy,
    output logic [31:0]        id_qry1_val,
    output logic [31:0]        id_qry2_val,
    input  logic               cdb_ena,
    input  logic [ROB_BIT-1:0] cdb_idx,
    input  logic [31:0]        cdb_val,
    input  logic               cdb_mispred,
    input  logic [31:0]        cdb_target,
    output logic               rob_wr_ena,
    output logic [4:0]         rob_wr_rd,
    output logic [31:0]        rob_wr_val,
    output logic [ROB_BIT-1:0] rob_wr_idx,
    output logic               rob_rb,
    output logic [31:0]        rob_rb_pc
);

    localparam logic [ROB_BIT-1:0] IDX_FIRST = ROB_BIT'(1);
    localparam logic [ROB_BIT-1:0] IDX_LAST  = ROB_BIT'(ROB_SIZE - 1);

    logic               ent_valid   [ROB_SIZE];
    logic               ent_ready   [ROB_SIZE];
    logic               ent_mispred [ROB_SIZE];
    logic [4:0]         ent_rd      [ROB_SIZE];
    logic [31:0]        ent_val     [ROB_SIZE];
    logic [31:0]        ent_target  [ROB_SIZE];

    logic [ROB_BIT-1:0] head;
    logic [ROB_BIT-1:0] tail;
    logic [ROB_BIT-1:0] count;

    logic active;
    logic do_alloc;
    logic cdb_hit;
    logic do_commit;
    logic do_rollback;

    // Tag 0 means "no dependency", so the ring runs over 1..ROB_SIZE-1.
    function automatic logic [ROB_BIT-1:0] inc_idx(input logic [ROB_BIT-1:0] i);
        return (i == IDX_LAST) ? IDX_FIRST : i + IDX_FIRST;
    endfunction

    // Allocation handshake: id_alloc_ena is the valid, !rob_full is the ready; an
    // entry is taken only on an active cycle (rdy && !rob_st) when both are high.
    assign active      = rdy && !rob_st;
    assign rob_full    = (count == IDX_LAST);
    assign id_rn_idx   = tail;
    assign do_alloc    = active && id_alloc_ena && !rob_full;
    assign cdb_hit     = active && cdb_ena && (cdb_idx != '0) && ent_valid[cdb_idx];
    assign do_commit   = active && (count != '0) && ent_ready[head];
    assign do_rollback = do_commit && ent_mispred[head];

    always_comb begin
        rob_wr_ena = 1'b0;
        rob_wr_rd  = '0;
        rob_wr_val = '0;
        rob_wr_idx = '0;
        rob_rb     = 1'b0;
        rob_rb_pc  = '0;
        if (do_commit) begin
            rob_wr_ena = (ent_rd[head] != 5'd0);
            rob_wr_rd  = ent_rd[head];
            rob_wr_val = ent_val[head];
            rob_wr_idx = head;
            rob_rb     = ent_mispred[head];
            rob_rb_pc  = ent_mispred[head] ? ent_target[head] : 32'd0;
        end
    end

    // Operand lookup with same-cycle CDB forwarding.
    always_comb begin
        id_qry1_rdy = 1'b0;
        id_qry1_val = '0;
        if (id_qry1_idx == '0) begin
            id_qry1_rdy = 1'b1;
        end else if (cdb_ena && (cdb_idx == id_qry1_idx)) begin
            id_qry1_rdy = 1'b1;
            id_qry1_val = cdb_val;
        end else begin
            id_qry1_rdy = ent_valid[id_qry1_idx] && ent_ready[id_qry1_idx];
            id_qry1_val = ent_val[id_qry1_idx];
        end
    end

    always_comb begin
        id_qry2_rdy = 1'b0;
        id_qry2_val = '0;
        if (id_qry2_idx == '0) begin
            id_qry2_rdy = 1'b1;
        end else if (cdb_ena && (cdb_idx == id_qry2_idx)) begin
            id_qry2_rdy = 1'b1;
            id_qry2_val = cdb_val;
        end else begin
            id_qry2_rdy = ent_valid[id_qry2_idx] && ent_ready[id_qry2_idx];
            id_qry2_val = ent_val[id_qry2_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= IDX_FIRST;
            tail  <= IDX_FIRST;
            count <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                ent_valid[i]   <= 1'b0;
                ent_ready[i]   <= 1'b0;
                ent_mispred[i] <= 1'b0;
                ent_rd[i]      <= '0;
                ent_val[i]     <= '0;
                ent_target[i]  <= '0;
            end
        end else if (do_rollback) begin
            // Everything younger than the mispredicted branch is wrong-path work.
            head  <= IDX_FIRST;
            tail  <= IDX_FIRST;
            count <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                ent_valid[i]   <= 1'b0;
                ent_ready[i]   <= 1'b0;
                ent_mispred[i] <= 1'b0;
            end
        end else begin
            if (do_alloc) begin
                ent_valid[tail]   <= 1'b1;
                ent_ready[tail]   <= 1'b0;
                ent_mispred[tail] <= 1'b0;
                ent_rd[tail]      <= id_alloc_rd;
                tail              <= inc_idx(tail);
            end
            if (cdb_hit) begin
                ent_ready[cdb_idx]   <= 1'b1;
                ent_val[cdb_idx]     <= cdb_val;
                ent_mispred[cdb_idx] <= cdb_mispred;
                ent_target[cdb_idx]  <= cdb_target;
            end
            if (do_commit) begin
                ent_valid[head] <= 1'b0;
                ent_ready[head] <= 1'b0;
                head            <= inc_idx(head);
            end
            case ({do_alloc, do_commit})
                2'b10:   count <= count + IDX_FIRST;
                2'b01:   count <= count - IDX_FIRST;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: allocation, CDB writeback, in-order commit,
// bypass, x0 retire, rollback, stall and mid-operation reset.
module tb_rob_commit_unit;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rob_st;
    logic        id_alloc_ena;
    logic [4:0]  id_alloc_rd;
    logic        rob_full;
    logic [3:0]  id_rn_idx;
    logic [3:0]  id_qry1_idx;
    logic [3:0]  id_qry2_idx;
    logic        id_qry1_rdy;
    logic        id_qry2_rdy;
    logic [31:0] id_qry1_val;
    logic [31:0] id_qry2_val;
    logic        cdb_ena;
    logic [3:0]  cdb_idx;
    logic [31:0] cdb_val;
    logic        cdb_mispred;
    logic [31:0] cdb_target;
    logic        rob_wr_ena;
    logic [4:0]  rob_wr_rd;
    logic [31:0] rob_wr_val;
    logic [3:0]  rob_wr_idx;
    logic        rob_rb;
    logic [31:0] rob_rb_pc;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    rob_commit_unit #(.ROB_BIT(4), .ROB_SIZE(16)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rob_st(rob_st),
        .id_alloc_ena(id_alloc_ena), .id_alloc_rd(id_alloc_rd),
        .rob_full(rob_full), .id_rn_idx(id_rn_idx),
        .id_qry1_idx(id_qry1_idx), .id_qry2_idx(id_qry2_idx),
        .id_qry1_rdy(id_qry1_rdy), .id_qry2_rdy(id_qry2_rdy),
        .id_qry1_val(id_qry1_val), .id_qry2_val(id_qry2_val),
        .cdb_ena(cdb_ena), .cdb_idx(cdb_idx), .cdb_val(cdb_val),
        .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
        .rob_wr_ena(rob_wr_ena), .rob_wr_rd(rob_wr_rd), .rob_wr_val(rob_wr_val),
        .rob_wr_idx(rob_wr_idx), .rob_rb(rob_rb), .rob_rb_pc(rob_rb_pc)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the edge, outputs are sampled 2 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        rdy          = 1'b1;
        rob_st       = 1'b0;
        id_alloc_ena = 1'b0;
        id_alloc_rd  = '0;
        id_qry1_idx  = '0;
        id_qry2_idx  = '0;
        cdb_ena      = 1'b0;
        cdb_idx      = '0;
        cdb_val      = '0;
        cdb_mispred  = 1'b0;
        cdb_target   = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic alloc(input logic [4:0] rd);
        idle();
        id_alloc_ena = 1'b1;
        id_alloc_rd  = rd;
        step();
        idle();
    endtask

    task automatic cdb(input logic [3:0] idx, input logic [31:0] val);
        idle();
        cdb_ena = 1'b1;
        cdb_idx = idx;
        cdb_val = val;
        step();
        idle();
    endtask

    initial begin
        #1;
        // Reset state
        idle();
        rst = 1'b0;
        step();
        step();
        settle();
        chk("rst_full", rob_full, 0);
        chk("rst_rn_idx", id_rn_idx, 1);
        chk("rst_wr_ena", rob_wr_ena, 0);
        chk("rst_rb", rob_rb, 0);
        chk("rst_wr_val", rob_wr_val, 0);
        chk("rst_rb_pc", rob_rb_pc, 0);
        step();
        rst = 1'b1;

        // Single alloc / writeback / commit
        id_alloc_ena = 1'b1;
        id_alloc_rd  = 5'd5;
        settle();
        chk("t1_rn_before", id_rn_idx, 1);
        step();
        idle();
        settle();
        chk("t1_rn_after", id_rn_idx, 2);
        chk("t1_no_commit_early", rob_wr_ena, 0);
        step();
        cdb_ena = 1'b1;
        cdb_idx = 4'd1;
        cdb_val = 32'hDEAD;
        settle();
        chk("t1_cdb_cycle_no_commit", rob_wr_ena, 0);
        step();
        idle();
        settle();
        chk("t1_wr_ena", rob_wr_ena, 1);
        chk("t1_wr_rd", rob_wr_rd, 5);
        chk("t1_wr_val", rob_wr_val, 32'hDEAD);
        chk("t1_wr_idx", rob_wr_idx, 1);
        step();
        settle();
        chk("t1_after_commit", rob_wr_ena, 0);

        // Fill to capacity, overflow, wrap
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            alloc(5'(i));
        end
        settle();
        chk("t2_full", rob_full, 1);
        chk("t2_tail_wrapped", id_rn_idx, 1);
        step();
        id_alloc_ena = 1'b1;
        id_alloc_rd  = 5'd7;
        step();
        idle();
        settle();
        chk("t2_overflow_ignored", id_rn_idx, 1);
        chk("t2_still_full", rob_full, 1);
        step();
        cdb(4'd1, 32'h111);
        id_alloc_ena = 1'b1;
        id_alloc_rd  = 5'd9;
        settle();
        chk("t2_commit_ena", rob_wr_ena, 1);
        chk("t2_commit_idx", rob_wr_idx, 1);
        chk("t2_full_during_commit", rob_full, 1);
        step();
        idle();
        settle();
        chk("t2_full_drops", rob_full, 0);
        chk("t2_alloc_not_unblocked", id_rn_idx, 1);
        step();
        id_alloc_ena = 1'b1;
        id_alloc_rd  = 5'd3;
        settle();
        chk("t2_wrap_tag", id_rn_idx, 1);
        step();
        idle();
        settle();
        chk("t2_wrap_tail", id_rn_idx, 2);
        chk("t2_full_again", rob_full, 1);

        // Out-of-order writeback, in-order commit
        do_reset();
        alloc(5'd1);
        alloc(5'd2);
        alloc(5'd3);
        cdb(4'd3, 32'h333);
        id_qry1_idx = 4'd3;
        id_qry2_idx = 4'd2;
        settle();
        chk("t3_qry3_rdy", id_qry1_rdy, 1);
        chk("t3_qry3_val", id_qry1_val, 32'h333);
        chk("t3_qry2_not_rdy", id_qry2_rdy, 0);
        chk("t3_head_waits", rob_wr_ena, 0);
        step();
        cdb(4'd2, 32'h222);
        cdb_ena = 1'b1;
        cdb_idx = 4'd1;
        cdb_val = 32'h111;
        settle();
        chk("t3_head_still_waits", rob_wr_ena, 0);
        step();
        idle();
        exp_q.push_back(32'h111);
        exp_q.push_back(32'h222);
        exp_q.push_back(32'h333);
        for (int i = 1; i <= 3; i++) begin
            settle();
            chk("t3_order_ena", rob_wr_ena, 1);
            chk("t3_order_idx", rob_wr_idx, i);
            chk("t3_order_val", rob_wr_val, exp_q.pop_front());
            step();
        end
        settle();
        chk("t3_drained", rob_wr_ena, 0);
        chk("t3_next_tag", id_rn_idx, 4);

        // CDB bypass and x0 retire
        do_reset();
        alloc(5'd0);
        alloc(5'd6);
        cdb_ena     = 1'b1;
        cdb_idx     = 4'd2;
        cdb_val     = 32'h42;
        id_qry1_idx = 4'd2;
        id_qry2_idx = 4'd1;
        settle();
        chk("t4_bypass_rdy", id_qry1_rdy, 1);
        chk("t4_bypass_val", id_qry1_val, 32'h42);
        chk("t4_other_not_rdy", id_qry2_rdy, 0);
        step();
        idle();
        id_qry1_idx = 4'd0;
        settle();
        chk("t4_qry0_rdy", id_qry1_rdy, 1);
        chk("t4_qry0_val", id_qry1_val, 0);
        step();
        cdb(4'd1, 32'h10);
        settle();
        chk("t4_x0_no_write", rob_wr_ena, 0);
        chk("t4_x0_idx", rob_wr_idx, 1);
        step();
        settle();
        chk("t4_next_ena", rob_wr_ena, 1);
        chk("t4_next_rd", rob_wr_rd, 6);
        chk("t4_next_val", rob_wr_val, 32'h42);
        step();
        settle();
        chk("t4_empty_no_commit", rob_wr_idx, 0);

        // Rollback
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            alloc(5'(i));
        end
        idle();
        cdb_ena     = 1'b1;
        cdb_idx     = 4'd1;
        cdb_val     = 32'h55;
        cdb_mispred = 1'b1;
        cdb_target  = 32'h1000;
        step();
        idle();
        id_alloc_ena = 1'b1;
        id_alloc_rd  = 5'd8;
        cdb_ena      = 1'b1;
        cdb_idx      = 4'd2;
        cdb_val      = 32'h77;
        settle();
        chk("t5_rb", rob_rb, 1);
        chk("t5_rb_pc", rob_rb_pc, 32'h1000);
        chk("t5_wr_ena", rob_wr_ena, 1);
        chk("t5_wr_val", rob_wr_val, 32'h55);
        step();
        idle();
        id_qry1_idx = 4'd2;
        settle();
        chk("t5_rb_pulse", rob_rb, 0);
        chk("t5_tail_reset", id_rn_idx, 1);
        chk("t5_empty", rob_wr_ena, 0);
        chk("t5_cdb_discarded", id_qry1_rdy, 0);

        // Stall and mid-operation reset
        do_reset();
        alloc(5'd4);
        cdb(4'd1, 32'hAB);
        rdy          = 1'b0;
        id_alloc_ena = 1'b1;
        id_alloc_rd  = 5'd2;
        settle();
        chk("t6_rdy0_no_commit", rob_wr_ena, 0);
        step();
        settle();
        chk("t6_rdy0_frozen", id_rn_idx, 2);
        step();
        idle();
        rob_st = 1'b1;
        settle();
        chk("t6_st_no_commit", rob_wr_ena, 0);
        step();
        rob_st = 1'b0;
        settle();
        chk("t6_resume_ena", rob_wr_ena, 1);
        chk("t6_resume_val", rob_wr_val, 32'hAB);
        step();
        alloc(5'd7);
        alloc(5'd8);
        cdb(4'd2, 32'h99);
        rst = 1'b0;
        step();
        rst = 1'b1;
        id_qry1_idx = 4'd2;
        settle();
        chk("t6_rst_tail", id_rn_idx, 1);
        chk("t6_rst_no_commit", rob_wr_ena, 0);
        chk("t6_rst_cleared", id_qry1_rdy, 0);
        chk("t6_rst_not_full", rob_full, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
